kronos_wb_arbiter: RTL and testbench
====================================

// Module: kronos_wb_arbiter
// PURPOSE
//   Shares the single integer-register write port (regwr_en/sel/data into the decode stage's regfile)
//   between two writeback requesters: EX (ALU results) and LSU (load data).
//   Arbitrates per cycle, accepts one write per cycle and registers it onto the regfile write port.
//   Fixed priority with an anti-starvation counter; round-robin is optional.
// PARAMETERS
//   MAX_WAIT  3  cycles EX may lose to LSU back-to-back before EX is force-granted once (range 1..15)
// PORTS
//   clk          in   1   core clock, all state on posedge
//   rstz         in   1   asynchronous active-low reset
//   ex_vld       in   1   EX writeback request valid
//   ex_rdy       out  1   EX request accepted this cycle (ex_vld & ex_rdy = handshake)
//   ex_rd        in   5   EX destination register index
//   ex_data      in   32  EX result
//   lsu_vld      in   1   LSU writeback request valid
//   lsu_rdy      out  1   LSU request accepted this cycle
//   lsu_rd       in   5   LSU destination register index
//   lsu_data     in   32  LSU load data
//   regwr_en     out  1   regfile write strobe (registered)
//   regwr_sel    out  5   regfile write index (registered)
//   regwr_data   out  32  regfile write data (registered)
//   wb_conflict  out  1   registered pulse: both requesters valid in the previous cycle
// BEHAVIOUR
// - Reset (rstz low, async): regwr_en=0, regwr_sel=0, regwr_data=0, wb_conflict=0, wait_cnt=0, last_grant=EX.
// - Grant is combinational from ex_vld/lsu_vld and arbiter state; at most one of ex_rdy/lsu_rdy is high.
//   ex_rdy/lsu_rdy are low when the own vld is low. No output backpressure: a lone valid requester is
//   granted in the same cycle.
// - Requesters hold vld, rd and data stable until handshake; ex_rdy may depend on lsu_vld and vice versa.
// - Latency: handshake in cycle N -> regwr_en=1 with that rd/data in cycle N+1, for exactly one cycle.
//   No handshake in cycle N -> regwr_en=0 in N+1. regwr_sel/regwr_data update only on a handshake, else hold.
// - rd==0: handshake completes normally; regwr_en stays 0 (x0 is never written); sel/data hold.
// - Fixed priority (default): LSU wins a conflict unless wait_cnt==MAX_WAIT, in which case EX wins.
//   wait_cnt (4b): +1 each cycle ex_vld & lsu granted; cleared on any EX handshake; saturates at MAX_WAIT.
//   Cleared whenever ex_vld=0.
// - Simultaneous requests to the same rd: written in grant order on consecutive cycles; the later grant wins.
// - wb_conflict(N+1) = ex_vld & lsu_vld in cycle N.
// - Reset mid-operation: an accepted-but-unwritten request (regwr_en due next cycle) is dropped; no write occurs.
// CONFIGURATION
// - KRONOS_WB_RR_EN defined: round-robin. On a conflict, grant the requester opposite to last_grant.
//   last_grant updates on every handshake. Reset value EX, so the first conflict grants LSU.
//   wait_cnt and MAX_WAIT are unused (wait_cnt held at 0).
// - Undefined: fixed-priority + anti-starvation as above; last_grant unused.
// TESTING
// 1. Reset asserted -> regwr_en=0, regwr_sel=0, regwr_data=0, wb_conflict=0, ex_rdy=lsu_rdy=0 with no vld.
// 2. ex_vld=1 rd=5 data=32'hDEADBEEF, lsu idle -> ex_rdy=1 same cycle; next cycle regwr_en=1 sel=5
//    data=DEADBEEF; cycle after, regwr_en=0.
// 3. lsu_vld=1 rd=0 data=32'h1234 -> lsu_rdy=1; regwr_en stays 0 throughout; regwr_sel/regwr_data unchanged.
// 4. Fixed, MAX_WAIT=3, ex_vld & lsu_vld held 5 cycles with new LSU data each handshake -> grants L,L,L,E,L.
//    wb_conflict=1 on the 5 following cycles.
// 5. KRONOS_WB_RR_EN, both vld held 4 cycles -> grants L,E,L,E; regwr_sel follows the lsu_rd/ex_rd order.
// 6. ex handshake rd=7 in cycle N, rstz pulsed low in cycle N+1 before the edge -> regwr_en=0;
//    reg 7 not written; after release, state equals post-reset.

Source files
------------

// File: rtl/kronos_wb_arbiter_if.sv
// Writeback bus shared by the EX and LSU requesters and the regfile write port.
// master = requester/regfile side, slave = arbiter side.
interface kronos_wb_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              ex_vld;
    logic              ex_rdy;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_data;
    logic              lsu_vld;
    logic              lsu_rdy;
    logic [4:0]        lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              regwr_en;
    logic [4:0]        regwr_sel;
    logic [DATA_W-1:0] regwr_data;
    logic              wb_conflict;

    modport master (
        output ex_vld, ex_rd, ex_data, lsu_vld, lsu_rd, lsu_data,
        input  ex_rdy, lsu_rdy, regwr_en, regwr_sel, regwr_data, wb_conflict
    );

    modport slave (
        input  ex_vld, ex_rd, ex_data, lsu_vld, lsu_rd, lsu_data,
        output ex_rdy, lsu_rdy, regwr_en, regwr_sel, regwr_data, wb_conflict
    );
endinterface

// File: rtl/kronos_wb_arbiter.sv
// Arbitrates EX and LSU writebacks onto the single regfile write port, one write per cycle.
// Default: LSU priority with EX anti-starvation; define KRONOS_WB_RR_EN for round-robin.
module kronos_wb_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input logic                 clk,
    input logic                 rstz,
    kronos_wb_arbiter_if.slave  wb
);
    localparam int DATA_W = 32;

    logic              both_vld;
    logic              ex_first;
    logic              grant_ex;
    logic              grant_lsu;
    logic              hs_vld;
    logic [4:0]        win_rd;
    logic [DATA_W-1:0] win_data;
    logic              wr_vld;

    logic              regwr_en_p1;
    logic [4:0]        regwr_sel_p1;
    logic [DATA_W-1:0] regwr_data_p1;
    logic              wb_conflict_p1;

`ifdef KRONOS_WB_RR_EN
    typedef enum logic {
        GRANT_EX  = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    grant_t last_grant;

    assign ex_first = (last_grant == GRANT_LSU);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            last_grant <= GRANT_EX;
        end else if (grant_ex) begin
            last_grant <= GRANT_EX;
        end else if (grant_lsu) begin
            last_grant <= GRANT_LSU;
        end
    end
`else
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    assign ex_first = (wait_cnt == WAIT_LIMIT);

    // Counts consecutive cycles EX was pending but lost to LSU.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wait_cnt <= 4'd0;
        end else if (!wb.ex_vld || grant_ex) begin
            wait_cnt <= 4'd0;
        end else if (grant_lsu && wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    assign both_vld = wb.ex_vld & wb.lsu_vld;

    always_comb begin
        grant_ex  = 1'b0;
        grant_lsu = 1'b0;
        if (wb.ex_vld && (!wb.lsu_vld || ex_first)) begin
            grant_ex = 1'b1;
        end else if (wb.lsu_vld) begin
            grant_lsu = 1'b1;
        end
    end

    assign hs_vld   = grant_ex | grant_lsu;
    assign win_rd   = grant_ex ? wb.ex_rd   : wb.lsu_rd;
    assign win_data = grant_ex ? wb.ex_data : wb.lsu_data;
    assign wr_vld   = hs_vld && (win_rd != 5'd0);

    // Stage p1: registered regfile write port.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            regwr_en_p1    <= 1'b0;
            regwr_sel_p1   <= 5'd0;
            regwr_data_p1  <= '0;
            wb_conflict_p1 <= 1'b0;
        end else begin
            regwr_en_p1    <= wr_vld;
            wb_conflict_p1 <= both_vld;
            if (wr_vld) begin
                regwr_sel_p1  <= win_rd;
                regwr_data_p1 <= win_data;
            end
        end
    end

    assign wb.ex_rdy      = grant_ex;
    assign wb.lsu_rdy     = grant_lsu;
    assign wb.regwr_en    = regwr_en_p1;
    assign wb.regwr_sel   = regwr_sel_p1;
    assign wb.regwr_data  = regwr_data_p1;
    assign wb.wb_conflict = wb_conflict_p1;
endmodule

// File: tb/tb_kronos_wb_arbiter.sv
// Self-checking bench for kronos_wb_arbiter: directed scenarios plus random traffic against
// a transaction-level reference model and a regfile image built from the write port.
module tb_kronos_wb_arbiter;
    localparam int MAX_WAIT = 3;

    logic clk;
    logic rstz;

    kronos_wb_arbiter_if bus ();

    kronos_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk  (clk),
        .rstz (rstz),
        .wb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        exp_en;
    logic [4:0]  exp_sel;
    logic [31:0] exp_data;
    logic        exp_conflict;
    int          ex_lost;
    logic        last_was_lsu;
    logic [31:0] model_rf  [32];
    logic [31:0] shadow_rf [32];

    logic obs_ex_rdy, obs_lsu_rdy;
    logic hs_ex, hs_lsu;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Regfile image as seen through the DUT's write port
    always @(posedge clk) begin
        if (bus.regwr_en) shadow_rf[bus.regwr_sel] <= bus.regwr_data;
    end

    function automatic logic [1:0] ref_grant(input logic ev, input logic lv);
        logic ex_wins;
        if (ev && lv) begin
`ifdef KRONOS_WB_RR_EN
            ex_wins = last_was_lsu;
`else
            ex_wins = (ex_lost >= MAX_WAIT);
`endif
            return ex_wins ? 2'b10 : 2'b01;
        end
        return {ev, lv};
    endfunction

    task automatic model_reset();
        exp_en       = 1'b0;
        exp_sel      = 5'd0;
        exp_data     = 32'd0;
        exp_conflict = 1'b0;
        ex_lost      = 0;
        last_was_lsu = 1'b0;
    endtask

    task automatic model_accept(input logic [4:0] rd, input logic [31:0] data);
        if (rd != 5'd0) begin
            exp_en   = 1'b1;
            exp_sel  = rd;
            exp_data = data;
        end else begin
            exp_en = 1'b0;
        end
    endtask

    // One clock: entered at posedge+1 with inputs applied, leaves at next posedge+1.
    task automatic step();
        logic [1:0] g;
        @(negedge clk);
        g = ref_grant(bus.ex_vld, bus.lsu_vld);
        obs_ex_rdy  = bus.ex_rdy;
        obs_lsu_rdy = bus.lsu_rdy;
        chk("ex_rdy",      32'(bus.ex_rdy),      32'(g[1]));
        chk("lsu_rdy",     32'(bus.lsu_rdy),     32'(g[0]));
        chk("regwr_en",    32'(bus.regwr_en),    32'(exp_en));
        chk("regwr_sel",   32'(bus.regwr_sel),   32'(exp_sel));
        chk("regwr_data",  bus.regwr_data,       exp_data);
        chk("wb_conflict", 32'(bus.wb_conflict), 32'(exp_conflict));
        @(posedge clk);
        if (exp_en) model_rf[exp_sel] = exp_data;
        exp_conflict = bus.ex_vld && bus.lsu_vld;
        if (g[1])      model_accept(bus.ex_rd, bus.ex_data);
        else if (g[0]) model_accept(bus.lsu_rd, bus.lsu_data);
        else           exp_en = 1'b0;
        if (!bus.ex_vld || g[1]) ex_lost = 0;
        else                     ex_lost++;
        if (g != 2'b00) last_was_lsu = g[0];
        hs_ex  = g[1];
        hs_lsu = g[0];
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_vld   = 1'b0;
        bus.ex_rd    = 5'd0;
        bus.ex_data  = 32'd0;
        bus.lsu_vld  = 1'b0;
        bus.lsu_rd   = 5'd0;
        bus.lsu_data = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstz = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rstz = 1'b1;
        @(posedge clk);
        #1;
    endtask

    string pat;
    int    n_arb;
    logic [4:0] win_rd;

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i]  = 32'd0;
            shadow_rf[i] = 32'd0;
        end
        model_reset();
        hs_ex  = 1'b0;
        hs_lsu = 1'b0;
        idle_inputs();
        rstz = 1'b0;

        // Reset state
        #3;
        chk("rst_regwr_en",    32'(bus.regwr_en),    32'd0);
        chk("rst_regwr_sel",   32'(bus.regwr_sel),   32'd0);
        chk("rst_regwr_data",  bus.regwr_data,       32'd0);
        chk("rst_wb_conflict", 32'(bus.wb_conflict), 32'd0);
        chk("rst_ex_rdy",      32'(bus.ex_rdy),      32'd0);
        chk("rst_lsu_rdy",     32'(bus.lsu_rdy),     32'd0);
        @(posedge clk);
        @(negedge clk);
        rstz = 1'b1;
        @(posedge clk);
        #1;

        // Lone EX write, one-cycle latency, single-cycle strobe
        bus.ex_vld  = 1'b1;
        bus.ex_rd   = 5'd5;
        bus.ex_data = 32'hDEADBEEF;
        step();
        chk("ex_alone_rdy", 32'(obs_ex_rdy), 32'd1);
        bus.ex_vld = 1'b0;
        chk("ex_alone_en",   32'(bus.regwr_en),  32'd1);
        chk("ex_alone_sel",  32'(bus.regwr_sel), 32'd5);
        chk("ex_alone_data", bus.regwr_data,     32'hDEADBEEF);
        step();
        chk("ex_alone_en_off", 32'(bus.regwr_en), 32'd0);

        // LSU write to x0: accepted but never written
        bus.lsu_vld  = 1'b1;
        bus.lsu_rd   = 5'd0;
        bus.lsu_data = 32'h1234;
        step();
        chk("x0_rdy", 32'(obs_lsu_rdy), 32'd1);
        bus.lsu_vld = 1'b0;
        chk("x0_en",   32'(bus.regwr_en),  32'd0);
        chk("x0_sel",  32'(bus.regwr_sel), 32'd5);
        chk("x0_data", bus.regwr_data,     32'hDEADBEEF);
        step();
        chk("x0_en2", 32'(bus.regwr_en), 32'd0);

        // Sustained conflict from a clean reset
        do_reset();
`ifdef KRONOS_WB_RR_EN
        pat = "LELE";
`else
        pat = "LLLEL";
`endif
        n_arb = pat.len();
        bus.ex_vld   = 1'b1;
        bus.ex_rd    = 5'd9;
        bus.ex_data  = 32'h0000_0900;
        bus.lsu_vld  = 1'b1;
        bus.lsu_rd   = 5'd10;
        bus.lsu_data = 32'h0000_1000;
        for (int i = 0; i < n_arb; i++) begin
            win_rd = (pat[i] == "E") ? bus.ex_rd : bus.lsu_rd;
            step();
            chk("arb_grant_ex",  32'(obs_ex_rdy),  32'(pat[i] == "E"));
            chk("arb_grant_lsu", 32'(obs_lsu_rdy), 32'(pat[i] == "L"));
            chk("arb_sel",       32'(bus.regwr_sel),   32'(win_rd));
            chk("arb_conflict",  32'(bus.wb_conflict), 32'd1);
            if (obs_lsu_rdy) begin
                bus.lsu_rd   = 5'(11 + i);
                bus.lsu_data = 32'h0000_1001 + 32'(i);
            end
            if (obs_ex_rdy) begin
                bus.ex_rd   = 5'd20;
                bus.ex_data = 32'h0000_2000 + 32'(i);
            end
        end
        idle_inputs();
        step();
        step();

        // Reset while an accepted write is still in flight
        bus.ex_vld  = 1'b1;
        bus.ex_rd   = 5'd7;
        bus.ex_data = 32'h7777_0007;
        step();
        chk("drop_rdy", 32'(obs_ex_rdy), 32'd1);
        bus.ex_vld = 1'b0;
        #2;
        rstz = 1'b0;
        #1;
        chk("drop_en_in_rst", 32'(bus.regwr_en), 32'd0);
        model_reset();
        @(negedge clk);
        #1;
        rstz = 1'b1;
        @(posedge clk);
        #1;
        chk("drop_reg7",        shadow_rf[7],          32'd0);
        chk("drop_regwr_en",    32'(bus.regwr_en),    32'd0);
        chk("drop_regwr_sel",   32'(bus.regwr_sel),   32'd0);
        chk("drop_regwr_data",  bus.regwr_data,       32'd0);
        chk("drop_wb_conflict", 32'(bus.wb_conflict), 32'd0);

        // Random traffic; requesters hold their request until handshake
        hs_ex  = 1'b1;
        hs_lsu = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (hs_ex || !bus.ex_vld) begin
                bus.ex_vld  = ($urandom_range(0, 99) < 60);
                bus.ex_rd   = 5'($urandom_range(0, 7));
                bus.ex_data = $urandom;
            end
            if (hs_lsu || !bus.lsu_vld) begin
                bus.lsu_vld  = ($urandom_range(0, 99) < 75);
                bus.lsu_rd   = 5'($urandom_range(0, 7));
                bus.lsu_data = $urandom;
            end
            step();
        end
        idle_inputs();
        step();
        step();

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("regfile_x%0d", i), shadow_rf[i], model_rf[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
